// File: rtl/dct_row_scheduler.sv
// -----------------------------------------------------------------------------
// dct_row_scheduler
//
// Runs one 8x8 block through the row path of the DCT. For each row it:
//   1. reads COLS pixels from the pixel buffer at
//      base + row*LINE_STRIDE + col, pulsing pack_clr on the first read;
//   2. waits for the serial-to-parallel packer to report the row complete,
//      giving up with an err pulse if that takes too long;
//   3. offers the packed row to the 1-D row DCT (dct_start/dct_ready) and
//      holds it until the DCT takes it.
// When all ROWS rows have been transferred, block_done pulses once.
//
// Every output is a registered decode of the next state and next counters.
// Because of that, a start seen in cycle N gives rd_en in cycle N+1, and
// every output lines up with the state the FSM is in during that cycle.
//
// Ports
//   sys_clk     in   1       clock, rising edge
//   sys_rst_n   in   1       asynchronous active-low reset
//   start       in   1       begin a block (only looked at in IDLE)
//   abort       in   1       synchronous abort, overrides everything else
//   base_addr   in   ADDR_W  block base address, captured on accepted start
//   rd_en       out  1       pixel-buffer read strobe
//   rd_addr     out  ADDR_W  pixel-buffer read address (0 when not reading)
//   pack_clr    out  1       one-cycle pulse on the first read of every row
//   pack_done   in   1       packer has a complete row (level)
//   dct_start   out  1       packed row valid to the DCT
//   dct_ready   in   1       DCT accepts the row this cycle
//   dct_row     out  3       index of the current row
//   busy        out  1       high in every state except IDLE
//   block_done  out  1       one-cycle pulse, block finished
//   err         out  1       one-cycle pulse, packer timeout
// -----------------------------------------------------------------------------
module dct_row_scheduler #(
  parameter int ADDR_W      = 12,
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int LINE_STRIDE = 8,
  parameter int TIMEOUT     = 31
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pack_clr,
  input  logic              pack_done,
  output logic              dct_start,
  input  logic              dct_ready,
  output logic [2:0]        dct_row,
  output logic              busy,
  output logic              block_done,
  output logic              err
);

  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [2:0]        ROW_LAST = 3'(ROWS - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_PACK_WAIT,
    S_ISSUE,
    S_DONE
  } state_e;

  // FSM state and counters
  state_e              state_q, state_d;
  logic [2:0]          row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;

  // Registered outputs
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                pack_clr_q, pack_clr_d;
  logic                dct_start_q, dct_start_d;
  logic [2:0]          dct_row_q, dct_row_d;
  logic                busy_q, busy_d;
  logic                block_done_q, block_done_d;
  logic                err_q, err_d;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tcnt_d  = tcnt_q;
    base_d  = base_q;
    err_d   = 1'b0;

    if (abort) begin
      // Abort beats start, pack_done and dct_ready; no done/err is raised.
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      tcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_d  = base_addr;
            row_d   = '0;
            col_d   = '0;
            tcnt_d  = '0;
            state_d = S_READ;
          end
        end

        S_READ: begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            tcnt_d  = '0;
            state_d = S_PACK_WAIT;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end

        S_PACK_WAIT: begin
          // pack_done wins even on the very last allowed cycle.
          if (pack_done) begin
            state_d = S_ISSUE;
          end else if (tcnt_q == TCNT_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            row_d   = '0;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end

        S_ISSUE: begin
          // dct_start stays up until the DCT takes the row.
          if (dct_ready) begin
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + 3'd1;
              state_d = S_READ;
            end
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          state_d = S_IDLE;
          row_d   = '0;
        end

        default: begin
          state_d = S_IDLE;
          row_d   = '0;
          col_d   = '0;
          tcnt_d  = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    rd_en_d      = (state_d == S_READ);
    pack_clr_d   = (state_d == S_READ) && (col_d == '0);
    dct_start_d  = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
    block_done_d = (state_d == S_DONE);
    dct_row_d    = row_d;

    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    rd_addr_d = '0;
    if (rd_en_d) begin
      rd_addr_d = base_d
                + ADDR_W'(int'(row_d) * LINE_STRIDE)
                + ADDR_W'(col_d);
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      tcnt_q       <= '0;
      base_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      pack_clr_q   <= 1'b0;
      dct_start_q  <= 1'b0;
      dct_row_q    <= '0;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      tcnt_q       <= tcnt_d;
      base_q       <= base_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      pack_clr_q   <= pack_clr_d;
      dct_start_q  <= dct_start_d;
      dct_row_q    <= dct_row_d;
      busy_q       <= busy_d;
      block_done_q <= block_done_d;
      err_q        <= err_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign pack_clr   = pack_clr_q;
  assign dct_start  = dct_start_q;
  assign dct_row    = dct_row_q;
  assign busy       = busy_q;
  assign block_done = block_done_q;
  assign err        = err_q;

endmodule
